// File: rtl/fp_div.sv
// Iterative divider for the 8-bit minifloat (1 sign, 3 exponent bias 3, 4 mantissa).
// Restoring division yields one quotient bit per clock under a start/busy/done handshake.
module fp_div #(
    parameter int WIDTH      = 8,
    parameter int EXP_WIDTH  = 3,
    parameter int MANT_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             RoundU,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [5:0]       flags
);
    localparam int EW      = EXP_WIDTH + 2;
    localparam int RW      = MANT_WIDTH + 2;
    localparam int QW      = MANT_WIDTH + 3;
    localparam int CW      = $clog2(QW);
    localparam int BIAS    = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SPEC = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_NORM = 2'd3;

    logic [1:0]            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [WIDTH-1:0]      r_y;
    logic [5:0]            r_flags;

    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic                  r_round;
    logic                  r_sign;
    logic [RW-1:0]         r_rem;
    logic [MANT_WIDTH:0]   r_div;
    logic [QW-1:0]         r_q;
    logic [CW-1:0]         r_cnt;
    logic signed [EW-1:0]  r_exp;

    logic [EXP_WIDTH-1:0]  w_a_exp, w_b_exp, w_ra_exp, w_rb_exp;
    logic [MANT_WIDTH-1:0] w_a_man, w_b_man, w_ra_man, w_rb_man;
    logic                  w_in_special;
    logic                  w_ra_zero, w_ra_inf, w_ra_nan;
    logic                  w_rb_zero, w_rb_inf, w_rb_nan;
    logic                  w_ge;
    logic [RW-1:0]         w_rem_sub;

    assign w_a_exp  = a[WIDTH-2 -: EXP_WIDTH];
    assign w_b_exp  = b[WIDTH-2 -: EXP_WIDTH];
    assign w_a_man  = a[MANT_WIDTH-1:0];
    assign w_b_man  = b[MANT_WIDTH-1:0];
    assign w_ra_exp = r_a[WIDTH-2 -: EXP_WIDTH];
    assign w_rb_exp = r_b[WIDTH-2 -: EXP_WIDTH];
    assign w_ra_man = r_a[MANT_WIDTH-1:0];
    assign w_rb_man = r_b[MANT_WIDTH-1:0];

    // Zero exponent (subnormals flush) or all-ones exponent bypasses the divider.
    assign w_in_special = (w_a_exp == '0) || (w_a_exp == '1) ||
                          (w_b_exp == '0) || (w_b_exp == '1);

    assign w_ra_zero = (w_ra_exp == '0);
    assign w_ra_inf  = (w_ra_exp == '1) && (w_ra_man == '0);
    assign w_ra_nan  = (w_ra_exp == '1) && (w_ra_man != '0);
    assign w_rb_zero = (w_rb_exp == '0);
    assign w_rb_inf  = (w_rb_exp == '1) && (w_rb_man == '0);
    assign w_rb_nan  = (w_rb_exp == '1) && (w_rb_man != '0);

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = r_rem - {1'b0, r_div};

    logic [WIDTH-1:0] w_inf, w_nan, w_zero;
    assign w_inf  = {r_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    assign w_nan  = {r_sign, {EXP_WIDTH{1'b1}}, {(MANT_WIDTH-1){1'b0}}, 1'b1};
    assign w_zero = {r_sign, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_spec_y;
    logic [5:0]       w_spec_flags;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_spec_y     = w_zero;
        w_spec_flags = 6'b000001;
        if (w_ra_nan || w_rb_nan || (w_ra_zero && w_rb_zero) || (w_ra_inf && w_rb_inf)) begin
            w_spec_y        = w_nan;
            w_spec_flags[5] = 1'b1;
        end else if (w_ra_inf) begin
            w_spec_y = w_inf;
        end else if (w_ra_zero || w_rb_inf) begin
            w_spec_y = w_zero;
        end else if (w_rb_zero) begin
            w_spec_y        = w_inf;
            w_spec_flags[4] = 1'b1;
        end
    end

    logic [MANT_WIDTH-1:0] w_mant;
    logic                  w_g, w_st, w_inc;
    logic [MANT_WIDTH:0]   w_sum;
    logic signed [EW-1:0]  w_exp_n, w_exp_r;
    logic [WIDTH-1:0]      w_norm_y;
    logic [5:0]            w_norm_flags;

    always_comb begin
        if (r_q[QW-1]) begin
            w_mant  = r_q[QW-2:2];
            w_g     = r_q[1];
            w_st    = r_q[0] | (|r_rem);
            w_exp_n = r_exp;
        end else begin
            w_mant  = r_q[QW-3:1];
            w_g     = r_q[0];
            w_st    = |r_rem;
            w_exp_n = r_exp - EW'(1);
        end
        w_inc   = r_round & w_g & (w_st | w_mant[0]);
        w_sum   = {1'b0, w_mant} + {{MANT_WIDTH{1'b0}}, w_inc};
        // A rounding carry leaves the low bits at zero and bumps the exponent.
        w_exp_r = w_sum[MANT_WIDTH] ? (w_exp_n + EW'(1)) : w_exp_n;

        w_norm_y     = {r_sign, w_exp_r[EXP_WIDTH-1:0], w_sum[MANT_WIDTH-1:0]};
        w_norm_flags = {4'b0000, (w_g | w_st), 1'b0};
        if (w_exp_r >= $signed(EW'(EXP_MAX))) begin
            w_norm_y     = w_inf;
            w_norm_flags = 6'b001010;
        end else if (w_exp_r <= $signed(EW'(0))) begin
            w_norm_y     = w_zero;
            w_norm_flags = 6'b000110;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= '0;
            r_flags <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_busy  <= 1'b1;
                    r_state <= w_in_special ? S_SPEC : S_DIV;
                end
                S_SPEC: begin
                    r_y     <= w_spec_y;
                    r_flags <= w_spec_flags;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DIV: if (r_cnt == CW'(QW - 1)) r_state <= S_NORM;
                default: begin
                    r_y     <= w_norm_y;
                    r_flags <= w_norm_flags;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on an accepted start before use.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_a     <= a;
            r_b     <= b;
            r_round <= RoundU;
            r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
            r_rem   <= {2'b01, w_a_man};
            r_div   <= {1'b1, w_b_man};
            r_q     <= '0;
            r_cnt   <= '0;
            r_exp   <= $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp}) + $signed(EW'(BIAS));
        end else if (r_state == S_DIV) begin
            r_q   <= {r_q[QW-2:0], w_ge};
            r_rem <= w_ge ? {w_rem_sub[RW-2:0], 1'b0} : {r_rem[RW-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign y     = r_y;
    assign flags = r_flags;
endmodule
